// File: rtl/cacheline_mem_arbiter.sv
// ============================================================================
//  Module      : cacheline_mem_arbiter
//  Description : Shares one physical-memory cacheline port between the I-cache
//                and D-cache, one line transaction at a time, with wait counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cacheline_mem_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    input  logic              cnt_clear,
    output logic [CNT_W-1:0]  i_wait_cnt,
    output logic [CNT_W-1:0]  d_wait_cnt
);

    localparam int                c_OFF_W     = $clog2(LINE_W / 8);
    localparam logic [ADDR_W-1:0] c_ADDR_MASK = {ADDR_W{1'b1}} << c_OFF_W;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SERVE_I = 2'd1,
        S_SERVE_D = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_last_grant_d;
    logic                r_pmem_read;
    logic                r_pmem_write;
    logic [ADDR_W-1:0]   r_pmem_addr;
    logic [LINE_W-1:0]   r_pmem_wdata;
    logic [LINE_W-1:0]   r_i_rdata;
    logic [LINE_W-1:0]   r_d_rdata;
    logic                r_i_resp;
    logic                r_d_resp;
    logic [CNT_W-1:0]    r_i_cnt;
    logic [CNT_W-1:0]    r_d_cnt;

    logic w_d_req;
    logic w_grant_d;
    logic w_grant_i;

    // On conflict the side that did not win last time gets the port.
    assign w_d_req   = d_read | d_write;
    assign w_grant_d = w_d_req & (~i_read | ~r_last_grant_d);
    assign w_grant_i = i_read & (~w_d_req | r_last_grant_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_last_grant_d <= 1'b0;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_addr    <= '0;
            r_pmem_wdata   <= '0;
            r_i_rdata      <= '0;
            r_d_rdata      <= '0;
            r_i_resp       <= 1'b0;
            r_d_resp       <= 1'b0;
        end else begin
            r_i_resp <= 1'b0;
            r_d_resp <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_d) begin
                        r_state        <= S_SERVE_D;
                        r_last_grant_d <= 1'b1;
                        r_pmem_addr    <= d_addr & c_ADDR_MASK;
                        r_pmem_wdata   <= d_wdata;
                        r_pmem_write   <= d_write;
                        r_pmem_read    <= ~d_write;
                    end else if (w_grant_i) begin
                        r_state        <= S_SERVE_I;
                        r_last_grant_d <= 1'b0;
                        r_pmem_addr    <= i_addr & c_ADDR_MASK;
                        r_pmem_write   <= 1'b0;
                        r_pmem_read    <= 1'b1;
                    end
                end
                S_SERVE_I: begin
                    if (pmem_resp) begin
                        r_state      <= S_DONE;
                        r_pmem_read  <= 1'b0;
                        r_pmem_write <= 1'b0;
                        r_i_resp     <= 1'b1;
                        r_i_rdata    <= pmem_rdata;
                    end
                end
                S_SERVE_D: begin
                    if (pmem_resp) begin
                        r_state      <= S_DONE;
                        r_pmem_read  <= 1'b0;
                        r_pmem_write <= 1'b0;
                        r_d_resp     <= 1'b1;
                        if (r_pmem_read) begin
                            r_d_rdata <= pmem_rdata;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Saturating wait counters; clear takes priority over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i_cnt <= '0;
            r_d_cnt <= '0;
        end else if (cnt_clear) begin
            r_i_cnt <= '0;
            r_d_cnt <= '0;
        end else begin
            if (i_read && !r_i_resp && (r_i_cnt != {CNT_W{1'b1}})) begin
                r_i_cnt <= r_i_cnt + CNT_W'(1);
            end
            if (w_d_req && !r_d_resp && (r_d_cnt != {CNT_W{1'b1}})) begin
                r_d_cnt <= r_d_cnt + CNT_W'(1);
            end
        end
    end

    assign pmem_read  = r_pmem_read;
    assign pmem_write = r_pmem_write;
    assign pmem_addr  = r_pmem_addr;
    assign pmem_wdata = r_pmem_wdata;
    assign i_rdata    = r_i_rdata;
    assign d_rdata    = r_d_rdata;
    assign i_resp     = r_i_resp;
    assign d_resp     = r_d_resp;
    assign i_wait_cnt = r_i_cnt;
    assign d_wait_cnt = r_d_cnt;

endmodule

`default_nettype wire

// File: tb/tb_cacheline_mem_arbiter.sv
// ============================================================================
//  Module      : tb_cacheline_mem_arbiter
//  Description : Directed self-checking bench for cacheline_mem_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cacheline_mem_arbiter;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst;
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_addr;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;
    logic              cnt_clear;
    logic [CNT_W-1:0]  i_wait_cnt;
    logic [CNT_W-1:0]  d_wait_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [LINE_W-1:0] c_R0 = {8{32'h0BAD_F00D}};
    localparam logic [LINE_W-1:0] c_R1 = {8{32'h1111_0001}};
    localparam logic [LINE_W-1:0] c_R2 = {8{32'h2222_0002}};
    localparam logic [LINE_W-1:0] c_R3 = {8{32'h3333_0003}};
    localparam logic [LINE_W-1:0] c_R4 = {8{32'h4444_0004}};
    localparam logic [LINE_W-1:0] c_R5 = {8{32'h5555_0005}};
    localparam logic [LINE_W-1:0] c_JUNK = {8{32'hDEAD_BEEF}};
    localparam logic [LINE_W-1:0] c_WD = {32{8'hA5}};

    cacheline_mem_arbiter #(
        .LINE_W(LINE_W),
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .i_read    (i_read),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_resp    (i_resp),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_resp    (d_resp),
        .pmem_read (pmem_read),
        .pmem_write(pmem_write),
        .pmem_addr (pmem_addr),
        .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata),
        .pmem_resp (pmem_resp),
        .cnt_clear (cnt_clear),
        .i_wait_cnt(i_wait_cnt),
        .d_wait_cnt(d_wait_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for a strobe, checks it, answers with pmem_resp=1 the
    // same cycle, then checks the one-cycle response on the owning side.
    task automatic do_txn(input string tag, input logic exp_d, input logic [ADDR_W-1:0] exp_addr,
                          input logic exp_wr, input logic [LINE_W-1:0] mem_data,
                          input logic [LINE_W-1:0] exp_rdata);
        int n = 0;
        while (!(pmem_read || pmem_write) && n < 8) begin
            step();
            n++;
        end
        chk1({tag, "_pread"}, pmem_read, !exp_wr);
        chk1({tag, "_pwrite"}, pmem_write, exp_wr);
        chk({tag, "_paddr"}, LINE_W'(pmem_addr), LINE_W'(exp_addr));
        if (exp_wr) begin
            chk({tag, "_pwdata"}, pmem_wdata, d_wdata);
        end
        pmem_rdata = mem_data;
        pmem_resp  = 1'b1;
        step();
        pmem_resp  = 1'b0;
        chk1({tag, "_iresp"}, i_resp, !exp_d);
        chk1({tag, "_dresp"}, d_resp, exp_d);
        chk({tag, "_rdata"}, exp_d ? d_rdata : i_rdata, exp_rdata);
        chk1({tag, "_strobe_off"}, pmem_read | pmem_write, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        i_read = 1'b0; i_addr = '0;
        d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
        pmem_rdata = '0; pmem_resp = 1'b0; cnt_clear = 1'b0;
        step();
        step();

        // Reset state
        chk1("rst_pread", pmem_read, 1'b0);
        chk1("rst_pwrite", pmem_write, 1'b0);
        chk("rst_paddr", LINE_W'(pmem_addr), '0);
        chk("rst_pwdata", pmem_wdata, '0);
        chk1("rst_iresp", i_resp, 1'b0);
        chk1("rst_dresp", d_resp, 1'b0);
        chk("rst_irdata", i_rdata, '0);
        chk("rst_drdata", d_rdata, '0);
        chk("rst_icnt", LINE_W'(i_wait_cnt), '0);
        chk("rst_dcnt", LINE_W'(d_wait_cnt), '0);

        // 1: single I read, pmem_resp three cycles after the strobe
        rst = 1'b0;
        i_read = 1'b1; i_addr = 32'h0000_1234;
        step();
        chk1("t1_pread", pmem_read, 1'b1);
        chk1("t1_pwrite", pmem_write, 1'b0);
        chk("t1_paddr", LINE_W'(pmem_addr), LINE_W'(32'h0000_1220));
        step();
        step();
        chk1("t1_no_early_iresp", i_resp, 1'b0);
        step();
        pmem_rdata = c_R0; pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0;
        chk1("t1_iresp", i_resp, 1'b1);
        chk("t1_irdata", i_rdata, c_R0);
        chk1("t1_dresp", d_resp, 1'b0);
        chk1("t1_pread_off", pmem_read, 1'b0);
        i_read = 1'b0;
        step();
        chk1("t1_iresp_once", i_resp, 1'b0);
        chk("t1_icnt", LINE_W'(i_wait_cnt), LINE_W'(5));
        chk("t1_dcnt", LINE_W'(d_wait_cnt), '0);
        step();

        // 2: simultaneous requests after reset alternate D, I, D, I
        rst = 1'b1;
        step();
        rst = 1'b0;
        i_read = 1'b1; i_addr = 32'h0000_0100;
        d_read = 1'b1; d_addr = 32'h0000_0200;
        do_txn("t2_d1", 1'b1, 32'h0000_0200, 1'b0, c_R1, c_R1);
        do_txn("t2_i1", 1'b0, 32'h0000_0100, 1'b0, c_R2, c_R2);
        do_txn("t2_d2", 1'b1, 32'h0000_0200, 1'b0, c_R3, c_R3);
        do_txn("t2_i2", 1'b0, 32'h0000_0100, 1'b0, c_R4, c_R4);
        i_read = 1'b0; d_read = 1'b0;
        step();
        step();

        // 3: read+write together is a writeback; d_rdata keeps its old line
        d_read = 1'b1; d_write = 1'b1; d_addr = 32'h0000_0047; d_wdata = c_WD;
        do_txn("t3_wb", 1'b1, 32'h0000_0040, 1'b1, c_JUNK, c_R3);
        d_read = 1'b0; d_write = 1'b0;
        step();
        step();

        // 4: I drops its request mid-transaction; DONE grants nothing
        i_read = 1'b1; i_addr = 32'h0000_2000;
        step();
        chk1("t4_pread", pmem_read, 1'b1);
        step();
        i_read = 1'b0;
        step();
        step();
        chk1("t4_hold", pmem_read, 1'b1);
        chk("t4_paddr_stable", LINE_W'(pmem_addr), LINE_W'(32'h0000_2000));
        pmem_rdata = c_R5; pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0;
        chk1("t4_iresp", i_resp, 1'b1);
        chk("t4_irdata", i_rdata, c_R5);
        d_read = 1'b1; d_addr = 32'h0000_0300;
        step();
        chk1("t4_done_no_grant", pmem_read, 1'b0);
        chk1("t4_iresp_once", i_resp, 1'b0);
        step();
        chk1("t4_d_grant", pmem_read, 1'b1);
        chk("t4_d_paddr", LINE_W'(pmem_addr), LINE_W'(32'h0000_0300));

        // 5: asynchronous reset during SERVE_D, then a stray pmem_resp
        rst = 1'b1;
        #1;
        chk1("t5_async_pread", pmem_read, 1'b0);
        chk("t5_async_paddr", LINE_W'(pmem_addr), '0);
        step();
        rst = 1'b0; d_read = 1'b0;
        pmem_rdata = c_JUNK; pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0;
        chk1("t5_stray_iresp", i_resp, 1'b0);
        chk1("t5_stray_dresp", d_resp, 1'b0);
        chk("t5_drdata", d_rdata, '0);
        step();
        chk1("t5_idle_pread", pmem_read, 1'b0);

        // 6: wait counter saturation and clear
        d_read = 1'b1; d_addr = 32'h0000_0400;
        repeat (5) step();
        chk("t6_dcnt5", LINE_W'(d_wait_cnt), LINE_W'(5));
        repeat (15) step();
        chk("t6_dcnt_sat", LINE_W'(d_wait_cnt), LINE_W'(15));
        chk("t6_icnt", LINE_W'(i_wait_cnt), '0);
        cnt_clear = 1'b1;
        step();
        cnt_clear = 1'b0;
        chk("t6_dcnt_clr", LINE_W'(d_wait_cnt), '0);
        step();
        chk("t6_dcnt_restart", LINE_W'(d_wait_cnt), LINE_W'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
